// File: rtl/conv_encoder_punct.sv
// conv_encoder_punct: rate-1/2 K=7 convolutional encoder (g0=133o, g1=171o)
// with puncturing to rates 2/3 and 3/4. It takes a serial bit stream in and
// sends a serial coded bit stream out, with valid/ready flow control on both
// sides.
// Optional build macro CONV_TAIL_EN adds a Flush input and a Tail_Done output.
// A flush makes the encoder insert its own six zero tail bits.
module conv_encoder_punct #(
  parameter logic [1:0] DEFAULT_RATE = 2'b00
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [1:0] Rate,
  input  logic       In_Data,
  input  logic       In_Valid,
  output logic       In_Ready,
  output logic       Out_Data,
  output logic       Out_Valid,
  input  logic       Out_Ready
`ifdef CONV_TAIL_EN
  ,
  input  logic       Flush,
  output logic       Tail_Done
`endif
);

  // Keep mask for the current puncture phase: bit1 = keep A, bit0 = keep B.
  function automatic logic [1:0] keep_mask(input logic [1:0] rate, input logic [1:0] phase);
    logic [1:0] k;
    k = 2'b11;
    case (rate)
      2'b01:   k = (phase == 2'd1) ? 2'b10 : 2'b11;
      2'b10: begin
        case (phase)
          2'd1:    k = 2'b10;
          2'd2:    k = 2'b01;
          default: k = 2'b11;
        endcase
      end
      default: k = 2'b11;
    endcase
    return k;
  endfunction

  // Next puncture phase. Rate code 11 behaves like rate 1/2.
  function automatic logic [1:0] next_phase(input logic [1:0] rate, input logic [1:0] phase);
    logic [1:0] n;
    n = 2'd0;
    case (rate)
      2'b01:   n = (phase == 2'd0) ? 2'd1 : 2'd0;
      2'b10:   n = (phase == 2'd2) ? 2'd0 : phase + 2'd1;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  logic [6:1] sr_p0;      // encoder delay line, sr_p0[k] = s(k)
  logic [1:0] phase_p0;
  logic [1:0] rate_p0;
  logic [1:0] obuf_p1;    // output holding register, head at bit 0
  logic [1:0] ocnt_p1;    // pending output bits (0..2)

  logic       room;
  logic       acc_in;
  logic       step;
  logic       d_bit;
  logic       enc_a;
  logic       enc_b;
  logic [1:0] keep;

  // A new bit may enter when the buffer is empty or its last bit leaves this cycle.
  assign room = (ocnt_p1 == 2'd0) || ((ocnt_p1 == 2'd1) && Out_Ready);

`ifdef CONV_TAIL_EN
  typedef enum logic [1:0] {T_IDLE, T_RUN, T_DRAIN} tail_st_t;
  tail_st_t   tail_st;
  logic       flush_pend;
  logic [2:0] tail_cnt;
  logic       tail_done_q;
  logic       tail_acc;

  // Upstream input is blocked from the moment a flush is seen until the tail finishes.
  assign In_Ready  = Reset && !Start && room && (tail_st == T_IDLE) && !flush_pend && !Flush;
  assign tail_acc  = !Start && room && (tail_st == T_RUN);
  assign acc_in    = In_Valid && In_Ready;
  assign step      = acc_in || tail_acc;
  assign d_bit     = tail_acc ? 1'b0 : In_Data;
  assign Tail_Done = tail_done_q;

  // Tail sequencer: six internal zero bits, then a one-cycle done pulse once drained.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      tail_st     <= T_IDLE;
      flush_pend  <= 1'b0;
      tail_cnt    <= 3'd0;
      tail_done_q <= 1'b0;
    end else if (Start) begin
      tail_st     <= T_IDLE;
      flush_pend  <= 1'b0;
      tail_cnt    <= 3'd0;
      tail_done_q <= 1'b0;
    end else begin
      tail_done_q <= 1'b0;
      case (tail_st)
        T_IDLE: begin
          if (Flush || flush_pend) begin
            if (ocnt_p1 == 2'd0) begin
              tail_st    <= T_RUN;
              flush_pend <= 1'b0;
              tail_cnt   <= 3'd0;
            end else begin
              flush_pend <= 1'b1;
            end
          end
        end
        T_RUN: begin
          if (tail_acc) begin
            tail_cnt <= tail_cnt + 3'd1;
            if (tail_cnt == 3'd5) tail_st <= T_DRAIN;
          end
        end
        T_DRAIN: begin
          if (ocnt_p1 == 2'd0) begin
            tail_done_q <= 1'b1;
            tail_st     <= T_IDLE;
          end
        end
        default: tail_st <= T_IDLE;
      endcase
    end
  end
`else
  assign In_Ready = Reset && !Start && room;
  assign acc_in   = In_Valid && In_Ready;
  assign step     = acc_in;
  assign d_bit    = In_Data;
`endif

  // Encoder taps and puncture decision for the bit entering this cycle.
  always_comb begin
    enc_a = d_bit ^ sr_p0[2] ^ sr_p0[3] ^ sr_p0[5] ^ sr_p0[6];
    enc_b = d_bit ^ sr_p0[1] ^ sr_p0[2] ^ sr_p0[3] ^ sr_p0[6];
    keep  = keep_mask(rate_p0, phase_p0);
  end

  // ---- stage p0 -> p1: encoder state update and output buffer load/drain ----
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sr_p0    <= '0;
      phase_p0 <= 2'd0;
      rate_p0  <= DEFAULT_RATE;
      obuf_p1  <= 2'b00;
      ocnt_p1  <= 2'd0;
    end else if (Start) begin
      sr_p0    <= '0;
      phase_p0 <= 2'd0;
      rate_p0  <= Rate;
      obuf_p1  <= 2'b00;
      ocnt_p1  <= 2'd0;
    end else if (step) begin
      sr_p0    <= {sr_p0[5:1], d_bit};
      phase_p0 <= next_phase(rate_p0, phase_p0);
      case (keep)
        2'b11: begin
          obuf_p1 <= {enc_b, enc_a};
          ocnt_p1 <= 2'd2;
        end
        2'b10: begin
          obuf_p1 <= {1'b0, enc_a};
          ocnt_p1 <= 2'd1;
        end
        default: begin
          obuf_p1 <= {1'b0, enc_b};
          ocnt_p1 <= 2'd1;
        end
      endcase
    end else if ((ocnt_p1 != 2'd0) && Out_Ready) begin
      obuf_p1 <= {1'b0, obuf_p1[1]};
      ocnt_p1 <= ocnt_p1 - 2'd1;
    end
  end

  assign Out_Data  = obuf_p1[0];
  assign Out_Valid = (ocnt_p1 != 2'd0);

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Directed bench for conv_encoder_punct: table of rate/impulse vectors plus
// hand-written backpressure, Start-abort, async-reset and (optional) tail cases.
module tb_conv_encoder_punct;

  logic       Clock;
  logic       Reset;
  logic       Start;
  logic [1:0] Rate;
  logic       In_Data;
  logic       In_Valid;
  logic       In_Ready;
  logic       Out_Data;
  logic       Out_Valid;
  logic       Out_Ready;
`ifdef CONV_TAIL_EN
  logic       Flush;
  logic       Tail_Done;
`endif

  conv_encoder_punct #(.DEFAULT_RATE(2'b00)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .Rate      (Rate),
    .In_Data   (In_Data),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Out_Data  (Out_Data),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready)
`ifdef CONV_TAIL_EN
    ,
    .Flush     (Flush),
    .Tail_Done (Tail_Done)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [1:0]  rate;
    int          n_in;
    logic [15:0] din;   // MSB-first within n_in bits
    int          n_out;
    logic [15:0] dout;  // MSB-first within n_out bits
  } vec_t;

  vec_t vecs[5];
  logic got[$];
  int   total;
  int   bad;
  int   td_cnt;

  // Record every output bit that will transfer at the next rising edge.
  always @(negedge Clock) begin
    #2;
    if (Out_Valid && Out_Ready) got.push_back(Out_Data);
`ifdef CONV_TAIL_EN
    if (Tail_Done) td_cnt++;
`endif
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic send_bit(input logic b);
    logic ok;
    int   n;
    ok = 1'b0;
    n  = 0;
    In_Valid = 1'b1;
    In_Data  = b;
    while (!ok && n < 50) begin
      #1 ok = In_Ready;
      @(negedge Clock);
      n++;
    end
    In_Valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_start(input logic [1:0] r);
    Start = 1'b1;
    Rate  = r;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic feed(input int n_in, input logic [15:0] din);
    for (int i = 0; i < n_in; i++) send_bit(din[n_in-1-i]);
  endtask

  task automatic check_stream(input string name, input int n_out, input logic [15:0] dout);
    int n;
    n = 0;
    while (got.size() < n_out && n < 200) begin
      @(negedge Clock);
      n++;
    end
    repeat (6) @(negedge Clock);
    chk({name, "_len"}, got.size(), n_out);
    for (int i = 0; i < n_out && i < got.size(); i++)
      chk($sformatf("%s_bit%0d", name, i), {31'd0, got[i]}, {31'd0, dout[n_out-1-i]});
  endtask

  initial begin
    total = 0; bad = 0; td_cnt = 0;
    Reset = 1'b0; Start = 1'b0; Rate = 2'b00;
    In_Data = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b1;
`ifdef CONV_TAIL_EN
    Flush = 1'b0;
`endif

    vecs[0] = '{rate: 2'b00, n_in: 7, din: {9'd0, 7'b1000000}, n_out: 14, dout: {2'd0, 14'b11011111001011}};
    vecs[1] = '{rate: 2'b10, n_in: 6, din: {10'd0, 6'b100000}, n_out: 8,  dout: {8'd0, 8'b11011100}};
    vecs[2] = '{rate: 2'b01, n_in: 6, din: {10'd0, 6'b100000}, n_out: 9,  dout: {7'd0, 9'b110111001}};
    vecs[3] = '{rate: 2'b11, n_in: 7, din: {9'd0, 7'b1000000}, n_out: 14, dout: {2'd0, 14'b11011111001011}};
    vecs[4] = '{rate: 2'b00, n_in: 8, din: {8'd0, 8'b11000000}, n_out: 16, dout: 16'b1110100011100111};

    // Reset state
    @(negedge Clock);
    In_Valid = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, In_Ready}, 32'd0);
    chk("rst_out_valid", {31'd0, Out_Valid}, 32'd0);
    chk("rst_out_data", {31'd0, Out_Data}, 32'd0);
    In_Valid = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    #1 chk("post_rst_in_ready", {31'd0, In_Ready}, 32'd1);
    @(negedge Clock);

    // Table-driven rate vectors
    for (int v = 0; v < 5; v++) begin
      do_start(vecs[v].rate);
      got.delete();
      feed(vecs[v].n_in, vecs[v].din);
      check_stream($sformatf("vec%0d", v), vecs[v].n_out, vecs[v].dout);
    end

    // Backpressure: output frozen, input blocked, nothing lost
    do_start(2'b00);
    got.delete();
    send_bit(1'b1);
    Out_Ready = 1'b0;
    In_Valid  = 1'b1;
    In_Data   = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_valid%0d", c), {31'd0, Out_Valid}, 32'd1);
      chk($sformatf("bp_data%0d", c), {31'd0, Out_Data}, 32'd1);
      chk($sformatf("bp_in_ready%0d", c), {31'd0, In_Ready}, 32'd0);
      @(negedge Clock);
    end
    In_Valid  = 1'b0;
    Out_Ready = 1'b1;
    feed(6, 16'd0);
    check_stream("bp", 14, {2'd0, 14'b11011111001011});

    // Start mid-stream with a simultaneous input bit
    do_start(2'b00);
    got.delete();
    send_bit(1'b1);
    Out_Ready = 1'b0;
    Start     = 1'b1;
    Rate      = 2'b10;
    In_Valid  = 1'b1;
    In_Data   = 1'b1;
    #1 chk("start_in_ready", {31'd0, In_Ready}, 32'd0);
    @(negedge Clock);
    Start     = 1'b0;
    In_Valid  = 1'b0;
    Out_Ready = 1'b1;
    #1 chk("start_out_valid", {31'd0, Out_Valid}, 32'd0);
    got.delete();
    feed(6, {10'd0, 6'b100000});
    check_stream("start_r34", 8, {8'd0, 8'b11011100});

    // Asynchronous reset between clock edges
    do_start(2'b10);
    got.delete();
    send_bit(1'b1);
    Out_Ready = 1'b0;
    #2 Reset = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, Out_Valid}, 32'd0);
    chk("arst_in_ready", {31'd0, In_Ready}, 32'd0);
    chk("arst_out_data", {31'd0, Out_Data}, 32'd0);
    @(negedge Clock);
    Reset     = 1'b1;
    Out_Ready = 1'b1;
    got.delete();
    feed(7, {9'd0, 7'b1000000});
    check_stream("arst_impulse", 14, {2'd0, 14'b11011111001011});

`ifdef CONV_TAIL_EN
    // Encoder-generated tail after a single 1 at rate 1/2
    do_start(2'b00);
    got.delete();
    td_cnt = 0;
    send_bit(1'b1);
    Flush = 1'b1;
    @(negedge Clock);
    Flush = 1'b0;
    check_stream("tail", 14, {2'd0, 14'b11011111001011});
    chk("tail_done_cnt", td_cnt, 32'd1);
    got.delete();
    feed(7, {9'd0, 7'b1000000});
    check_stream("tail_after", 14, {2'd0, 14'b11011111001011});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
